alu_multicycle: RTL and testbench

- Parametrised, registered successor to the EX-stage combinational ALU for the multi-cycle CPU.
- Adds unsigned multiply (shift-add) and unsigned divide (restoring), both iterative, plus SRL/SRA and a correct signed SLT.
- Sits in EX behind the operand/forwarding muxes; the control FSM issues `start` and waits for `done`.
- All ops share one start/busy/done handshake, so the control unit can stall uniformly.

---
 rtl/alu_multicycle.sv | 172 +++++++++++++++++
 tb/tb_alu_multicycle.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Registered EX-stage ALU with iterative shift-add multiply and restoring divide.
// Every operation uses the same start/busy/done handshake so the control FSM can stall uniformly.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MULU = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd12;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIN
    } stateType;

    stateType         state;
    logic [WIDTH-1:0] count;
    logic             isDiv;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] accHi;
    logic [WIDTH-1:0] accLo;

    logic [WIDTH-1:0] aluOut;
    logic [SHW-1:0]   shAmt;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH:0]   divDiff;
    logic [WIDTH-1:0] nextHi;
    logic [WIDTH-1:0] nextLo;

    assign shAmt = srcA[SHW-1:0];

    // Single-cycle results come straight from the live operands, captured on the start edge.
    always_comb begin
        aluOut = '0;
        case (op)
            OP_ADD:  aluOut = srcA + srcB;
            OP_SUB:  aluOut = srcA - srcB;
            OP_AND:  aluOut = srcA & srcB;
            OP_OR:   aluOut = srcA | srcB;
            OP_XOR:  aluOut = srcA ^ srcB;
            OP_SLL:  aluOut = srcB << shAmt;
            OP_SRL:  aluOut = srcB >> shAmt;
            OP_SRA:  aluOut = $unsigned($signed(srcB) >>> shAmt);
            OP_SLT:  aluOut = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            OP_SLTU: aluOut = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
            default: aluOut = '0;
        endcase
    end

    // One iteration step; the last step is written straight into the outputs on the way to FIN.
    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : {(WIDTH+1){1'b0}});
        divShift = {accHi, accLo[WIDTH-1]};
        divDiff  = divShift - {1'b0, opB};
        nextHi   = '0;
        nextLo   = '0;
        if (isDiv) begin
            if (!divDiff[WIDTH]) begin
                nextHi = divDiff[WIDTH-1:0];
                nextLo = {accLo[WIDTH-2:0], 1'b1};
            end else begin
                nextHi = divShift[WIDTH-1:0];
                nextLo = {accLo[WIDTH-2:0], 1'b0};
            end
        end else begin
            nextHi = mulSum[WIDTH:1];
            nextLo = {mulSum[0], accLo[WIDTH-1:1]};
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= IDLE;
            count       <= '0;
            isDiv       <= 1'b0;
            opB         <= '0;
            accHi       <= '0;
            accLo       <= '0;
            result      <= '0;
            hi          <= '0;
            zero        <= 1'b1;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy  <= 1'b1;
                        count <= '0;
                        opB   <= srcB;
                        accHi <= '0;
                        accLo <= srcA;
                        if (op == OP_MULU) begin
                            isDiv <= 1'b0;
                            state <= ITER;
                        end else if (op == OP_DIVU && srcB != '0) begin
                            isDiv <= 1'b1;
                            state <= ITER;
                        end else if (op == OP_DIVU) begin
                            result      <= '1;
                            hi          <= srcA;
                            zero        <= 1'b0;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= FIN;
                        end else begin
                            result      <= aluOut;
                            hi          <= '0;
                            zero        <= (aluOut == '0);
                            div_by_zero <= 1'b0;
                            done        <= 1'b1;
                            state       <= FIN;
                        end
                    end
                end
                ITER: begin
                    count <= count + 1'b1;
                    accHi <= nextHi;
                    accLo <= nextLo;
                    if (count == WIDTH'(WIDTH - 1)) begin
                        result      <= nextLo;
                        hi          <= nextHi;
                        zero        <= (nextLo == '0);
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        state       <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle at WIDTH = 32.
`timescale 1ns/1ps
module tb_alu_multicycle;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] srcA = '0;
    logic [31:0] srcB = '0;
    logic [31:0] result;
    logic [31:0] hi;
    logic        zero;
    logic        div_by_zero;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;

    alu_multicycle #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
        .result(result), .hi(hi), .zero(zero), .div_by_zero(div_by_zero),
        .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    // Issue one op and return the number of edges until done is seen (-1 on timeout).
    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output int lat);
        @(negedge CLK);
        start = 1'b1; op = o; srcA = a; srcB = b;
        @(negedge CLK);
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        int doneSeen = 0;
        RST = 1'b0; start = 1'b1; op = 4'd0; srcA = 32'd1; srcB = 32'd2;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            if (done === 1'b1) doneSeen++;
        end
        total++; if (result !== 32'h0) begin bad++; $display("[TB] FAIL reset_result got=%h exp=%h", result, 32'h0); end
        total++; if (hi !== 32'h0) begin bad++; $display("[TB] FAIL reset_hi got=%h exp=%h", hi, 32'h0); end
        total++; if (zero !== 1'b1) begin bad++; $display("[TB] FAIL reset_zero got=%b exp=1", zero); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        start = 1'b0;
        RST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            if (done === 1'b1) doneSeen++;
        end
        total++; if (doneSeen !== 0) begin bad++; $display("[TB] FAIL reset_done got=%0d exp=0", doneSeen); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        int lat;
        applyStimulus(4'd1, 32'd5, 32'd7, lat);
        total++; if (lat !== 1) begin bad++; $display("[TB] FAIL sub_latency got=%0d exp=1", lat); end
        total++; if (result !== 32'hFFFFFFFE) begin bad++; $display("[TB] FAIL sub_result got=%h exp=FFFFFFFE", result); end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL sub_busy_fin got=%b exp=1", busy); end
        @(negedge CLK);
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL done_pulse_width got=%b exp=0", done); end
        applyStimulus(4'd5, 32'hFFFFFFFF, 32'd1, lat);
        total++; if (result !== 32'd1) begin bad++; $display("[TB] FAIL slt_result got=%h exp=1", result); end
        applyStimulus(4'd6, 32'hFFFFFFFF, 32'd1, lat);
        total++; if (result !== 32'd0 || zero !== 1'b1) begin bad++; $display("[TB] FAIL sltu_result got=%h/%b exp=0/1", result, zero); end
        applyStimulus(4'd9, 32'd4, 32'h80000000, lat);
        total++; if (result !== 32'hF8000000) begin bad++; $display("[TB] FAIL sra_result got=%h exp=F8000000", result); end
        applyStimulus(4'd8, 32'd4, 32'h80000000, lat);
        total++; if (result !== 32'h08000000) begin bad++; $display("[TB] FAIL srl_result got=%h exp=08000000", result); end
        applyStimulus(4'd4, 32'h23, 32'h3, lat);
        total++; if (result !== 32'h18) begin bad++; $display("[TB] FAIL sll_result got=%h exp=18", result); end
        applyStimulus(4'd7, 32'hF0F0F0F0, 32'hFF00FF00, lat);
        total++; if (result !== 32'h0FF00FF0) begin bad++; $display("[TB] FAIL xor_result got=%h exp=0FF00FF0", result); end
        applyStimulus(4'd0, 32'hFFFFFFFF, 32'd1, lat);
        total++; if (result !== 32'h0 || zero !== 1'b1) begin bad++; $display("[TB] FAIL add_wrap got=%h/%b exp=0/1", result, zero); end
        applyStimulus(4'd13, 32'd9, 32'd9, lat);
        total++; if (lat !== 1 || result !== 32'h0 || hi !== 32'h0 || zero !== 1'b1) begin
            bad++; $display("[TB] FAIL illegal_op got=lat%0d %h %h %b exp=lat1 0 0 1", lat, result, hi, zero);
        end
    endtask

    task automatic test_mulu();
        int lat;
        applyStimulus(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        total++; if (lat !== 33) begin bad++; $display("[TB] FAIL mulu_latency got=%0d exp=33", lat); end
        total++; if (hi !== 32'hFFFFFFFE || result !== 32'h1) begin bad++; $display("[TB] FAIL mulu_product got=%h_%h exp=FFFFFFFE_00000001", hi, result); end
        applyStimulus(4'd10, 32'd1234, 32'd5678, lat);
        total++; if (hi !== 32'h0 || result !== 32'd7006652 || zero !== 1'b0) begin bad++; $display("[TB] FAIL mulu_small got=%h_%h exp=0_%h", hi, result, 32'd7006652); end
    endtask

    task automatic test_divu();
        int lat;
        applyStimulus(4'd12, 32'd100, 32'd7, lat);
        total++; if (lat !== 33) begin bad++; $display("[TB] FAIL divu_latency got=%0d exp=33", lat); end
        total++; if (result !== 32'd14 || hi !== 32'd2 || div_by_zero !== 1'b0) begin bad++; $display("[TB] FAIL divu_100_7 got=%0d r%0d dz%b exp=14 r2 dz0", result, hi, div_by_zero); end
        applyStimulus(4'd12, 32'd100, 32'd0, lat);
        total++; if (lat !== 1) begin bad++; $display("[TB] FAIL divz_latency got=%0d exp=1", lat); end
        total++; if (result !== 32'hFFFFFFFF || hi !== 32'd100 || div_by_zero !== 1'b1) begin bad++; $display("[TB] FAIL divz_values got=%h %0d %b exp=FFFFFFFF 100 1", result, hi, div_by_zero); end
        applyStimulus(4'd0, 32'd1, 32'd1, lat);
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("[TB] FAIL divz_clear got=%b exp=0", div_by_zero); end
    endtask

    task automatic test_back_to_back();
        int doneCount = 0;
        int busyCount = 0;
        @(negedge CLK);
        start = 1'b1; op = 4'd10; srcA = 32'hFFFFFFFF; srcB = 32'hFFFFFFFF;
        @(negedge CLK);
        start = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            if (c > 1) @(negedge CLK);
            if (c <= 34 && done === 1'b1) doneCount++;
            if (c <= 33 && busy === 1'b1) busyCount++;
            if (c == 33) begin
                total++; if (done !== 1'b1 || result !== 32'h1 || hi !== 32'hFFFFFFFE) begin
                    bad++; $display("[TB] FAIL busy_mulu_result got=d%b %h_%h exp=d1 FFFFFFFE_00000001", done, hi, result);
                end
            end
            if (c == 34) begin
                total++; if (done !== 1'b0 || busy !== 1'b0 || result !== 32'h1) begin
                    bad++; $display("[TB] FAIL fin_start_ignored got=d%b b%b %h exp=d0 b0 1", done, busy, result);
                end
            end
            if (c == 35) begin
                total++; if (done !== 1'b1 || result !== 32'd7) begin
                    bad++; $display("[TB] FAIL reissue_accepted got=d%b %0d exp=d1 7", done, result);
                end
            end
            start = (c == 5 || c == 33 || c == 34) ? 1'b1 : 1'b0;
            op = 4'd0; srcA = 32'd3; srcB = 32'd4;
        end
        total++; if (doneCount !== 1) begin bad++; $display("[TB] FAIL busy_done_count got=%0d exp=1", doneCount); end
        total++; if (busyCount !== 33) begin bad++; $display("[TB] FAIL busy_high_cycles got=%0d exp=33", busyCount); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int doneSeen = 0;
        @(negedge CLK);
        start = 1'b1; op = 4'd12; srcA = 32'd100; srcB = 32'd7;
        @(negedge CLK);
        start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (c > 1) @(negedge CLK);
            if (done === 1'b1) doneSeen++;
            if (c == 11) begin
                total++; if (busy !== 1'b0 || result !== 32'h0 || hi !== 32'h0 || zero !== 1'b1 || div_by_zero !== 1'b0) begin
                    bad++; $display("[TB] FAIL midreset_outputs got=b%b %h %h z%b dz%b exp=b0 0 0 z1 dz0", busy, result, hi, zero, div_by_zero);
                end
            end
            RST = (c == 10) ? 1'b0 : 1'b1;
        end
        total++; if (doneSeen !== 0) begin bad++; $display("[TB] FAIL midreset_done got=%0d exp=0", doneSeen); end
        applyStimulus(4'd12, 32'd9, 32'd3, lat);
        total++; if (lat !== 33 || result !== 32'd3 || hi !== 32'd0) begin
            bad++; $display("[TB] FAIL div_after_reset got=lat%0d %0d r%0d exp=lat33 3 r0", lat, result, hi);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mulu();
        test_divu();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
